// File: rtl/digest_stream_merge.sv
// digest_stream_merge: merges a payload stream with a per-packet digest stream.
//   MODE=0 replaces the last payload beat with the digest; MODE=1 appends the
//   digest as an extra beat after the (re-flagged) last payload beat.
// Latency: one cycle from input accept to m_axis_tvalid (single output register).
// Backpressure: inputs are accepted only when the output slot is free
//   (!m_axis_tvalid || m_axis_tready); the output holds while stalled.
//
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   s_data_*                payload stream (tvalid/tready/tdata/tkeep/tid/tlast)
//   s_dig_*                 digest stream, one digest per packet, in packet order
//   m_axis_*                merged output stream
//   pkt_cnt                 packets completed on m_axis (wrapping)
//   id_err / id_err_cnt     tid mismatch pulse / saturating mismatch count
module digest_stream_merge #(
  parameter int DATA_W   = 512,
  parameter int DIGEST_W = 512,
  parameter int ID_W     = 6,
  parameter int MODE     = 0
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_data_tvalid,
  output logic                  s_data_tready,
  input  logic [DATA_W-1:0]     s_data_tdata,
  input  logic [DATA_W/8-1:0]   s_data_tkeep,
  input  logic [ID_W-1:0]       s_data_tid,
  input  logic                  s_data_tlast,
  input  logic                  s_dig_tvalid,
  output logic                  s_dig_tready,
  input  logic [DIGEST_W-1:0]   s_dig_tdata,
  input  logic [ID_W-1:0]       s_dig_tid,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic [ID_W-1:0]       m_axis_tid,
  output logic                  m_axis_tlast,
  output logic [31:0]           pkt_cnt,
  output logic                  id_err,
  output logic [15:0]           id_err_cnt
);

  localparam int KEEP_W   = DATA_W / 8;
  localparam int DKEEP_W  = DIGEST_W / 8;
  localparam bit APPEND   = (MODE != 0);

  typedef enum logic {
    S_DATA = 1'b0,
    S_DIG  = 1'b1
  } state_t;

  // FSM state and the tid of the packet whose digest is pending (append mode)
  state_t            state_q, state_d;
  logic [ID_W-1:0]   tid_q, tid_d;

  // Output register
  logic              m_vld_q, m_vld_d;
  logic [DATA_W-1:0] m_dat_q, m_dat_d;
  logic [KEEP_W-1:0] m_keep_q, m_keep_d;
  logic [ID_W-1:0]   m_tid_q, m_tid_d;
  logic              m_last_q, m_last_d;

  // Status
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic              id_err_q, id_err_d;
  logic [15:0]       id_err_cnt_q, id_err_cnt_d;

  // Combinational handshake / load controls
  logic              slot_free;
  logic              data_rdy;
  logic              dig_rdy;
  logic              load;
  logic              dig_hs;
  logic [ID_W-1:0]   exp_tid;
  logic [DATA_W-1:0] ld_dat;
  logic [KEEP_W-1:0] ld_keep;
  logic [ID_W-1:0]   ld_tid;
  logic              ld_last;
  logic [DATA_W-1:0] dig_ext;
  logic [KEEP_W-1:0] dig_keep;
  logic              tid_mismatch;

  assign slot_free = !m_vld_q || m_axis_tready;

  // Digest beat payload: digest zero-extended into the low bits, keep covers
  // exactly the digest bytes.
  always_comb begin
    dig_ext                  = '0;
    dig_ext[DIGEST_W-1:0]    = s_dig_tdata;
    dig_keep                 = '0;
    dig_keep[DKEEP_W-1:0]    = '1;
  end

  // Next-state and handshake logic
  always_comb begin
    state_d  = state_q;
    tid_d    = tid_q;
    data_rdy = 1'b0;
    dig_rdy  = 1'b0;
    load     = 1'b0;
    dig_hs   = 1'b0;
    exp_tid  = s_data_tid;
    ld_dat   = s_data_tdata;
    ld_keep  = s_data_tkeep;
    ld_tid   = s_data_tid;
    ld_last  = 1'b0;

    case (state_q)
      S_DATA: begin
        if (s_data_tvalid) begin
          if (!s_data_tlast) begin
            // Body beat passes through untouched.
            data_rdy = slot_free;
            load     = slot_free;
          end else if (!APPEND) begin
            // Last beat and digest are consumed together so the replaced
            // beat can be built in one cycle; neither side moves alone.
            data_rdy = s_dig_tvalid && slot_free;
            dig_rdy  = data_rdy;
            load     = data_rdy;
            dig_hs   = data_rdy;
            ld_dat   = dig_ext;
            ld_keep  = dig_keep;
            ld_last  = 1'b1;
          end else begin
            // Last payload beat goes out with tlast cleared; the digest
            // beat that follows carries the packet end.
            data_rdy = slot_free;
            load     = slot_free;
            if (slot_free) begin
              state_d = S_DIG;
              tid_d   = s_data_tid;
            end
          end
        end
      end

      S_DIG: begin
        dig_rdy = slot_free;
        exp_tid = tid_q;
        ld_dat  = dig_ext;
        ld_keep = dig_keep;
        ld_tid  = tid_q;
        ld_last = 1'b1;
        if (s_dig_tvalid && slot_free) begin
          load    = 1'b1;
          dig_hs  = 1'b1;
          state_d = S_DATA;
        end
      end

      default: begin
        state_d = S_DATA;
      end
    endcase
  end

  // Readies are forced low while reset is held so nothing handshakes
  // against a register bank that is being cleared.
  assign s_data_tready = data_rdy && !areset;
  assign s_dig_tready  = dig_rdy && !areset;

  assign tid_mismatch = dig_hs && (s_dig_tid != exp_tid);

  // Output register and status next-state
  always_comb begin
    m_vld_d      = m_vld_q;
    m_dat_d      = m_dat_q;
    m_keep_d     = m_keep_q;
    m_tid_d      = m_tid_q;
    m_last_d     = m_last_q;
    pkt_cnt_d    = pkt_cnt_q;
    id_err_d     = tid_mismatch;
    id_err_cnt_d = id_err_cnt_q;

    if (load) begin
      m_vld_d  = 1'b1;
      m_dat_d  = ld_dat;
      m_keep_d = ld_keep;
      m_tid_d  = ld_tid;
      m_last_d = ld_last;
    end else if (m_axis_tready) begin
      m_vld_d  = 1'b0;
    end

    if (m_vld_q && m_axis_tready && m_last_q) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end

    if (tid_mismatch && (id_err_cnt_q != 16'hFFFF)) begin
      id_err_cnt_d = id_err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_DATA;
      tid_q        <= '0;
      m_vld_q      <= 1'b0;
      m_dat_q      <= '0;
      m_keep_q     <= '0;
      m_tid_q      <= '0;
      m_last_q     <= 1'b0;
      pkt_cnt_q    <= '0;
      id_err_q     <= 1'b0;
      id_err_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      tid_q        <= tid_d;
      m_vld_q      <= m_vld_d;
      m_dat_q      <= m_dat_d;
      m_keep_q     <= m_keep_d;
      m_tid_q      <= m_tid_d;
      m_last_q     <= m_last_d;
      pkt_cnt_q    <= pkt_cnt_d;
      id_err_q     <= id_err_d;
      id_err_cnt_q <= id_err_cnt_d;
    end
  end

  assign m_axis_tvalid = m_vld_q;
  assign m_axis_tdata  = m_dat_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tid    = m_tid_q;
  assign m_axis_tlast  = m_last_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign id_err        = id_err_q;
  assign id_err_cnt    = id_err_cnt_q;

endmodule

// File: tb/tb_digest_stream_merge.sv
module tb_digest_stream_merge;

  typedef struct packed {
    logic [511:0] dat;
    logic [63:0]  keep;
    logic [5:0]   tid;
    logic         last;
  } beat_t;

  typedef struct packed {
    logic [3:0][511:0] dat;
    logic [3:0][63:0]  keep;
    logic [2:0]        n;
    logic [5:0]        tid;
    logic [5:0]        dtid;
    logic [511:0]      dig;
    logic [3:0]        ddly;
    logic              abort;
  } pkt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst [2];
  logic         dv [2], drdy [2], dl [2];
  logic [511:0] dd [2];
  logic [63:0]  dk [2];
  logic [5:0]   dt [2];
  logic         gv [2], grdy [2];
  logic [511:0] gd [2];
  logic [5:0]   gt [2];
  logic         mv [2], mr [2], ml [2];
  logic [511:0] md [2];
  logic [63:0]  mk [2];
  logic [5:0]   mt [2];
  logic [31:0]  pc [2];
  logic         ierr [2];
  logic [15:0]  ec [2];

  int checks = 0;
  int failures = 0;
  bit rand_mode = 1'b0;
  int exp_err [2];
  int errseen [2];

  pkt_t  dq0[$], dq1[$], gq0[$], gq1[$];
  beat_t eq0[$], eq1[$];

  digest_stream_merge #(.DATA_W(512), .DIGEST_W(512), .ID_W(6), .MODE(0)) u_m0 (
    .aclk(clk), .areset(rst[0]),
    .s_data_tvalid(dv[0]), .s_data_tready(drdy[0]), .s_data_tdata(dd[0]),
    .s_data_tkeep(dk[0]), .s_data_tid(dt[0]), .s_data_tlast(dl[0]),
    .s_dig_tvalid(gv[0]), .s_dig_tready(grdy[0]), .s_dig_tdata(gd[0]), .s_dig_tid(gt[0]),
    .m_axis_tvalid(mv[0]), .m_axis_tready(mr[0]), .m_axis_tdata(md[0]),
    .m_axis_tkeep(mk[0]), .m_axis_tid(mt[0]), .m_axis_tlast(ml[0]),
    .pkt_cnt(pc[0]), .id_err(ierr[0]), .id_err_cnt(ec[0])
  );

  digest_stream_merge #(.DATA_W(512), .DIGEST_W(256), .ID_W(6), .MODE(1)) u_m1 (
    .aclk(clk), .areset(rst[1]),
    .s_data_tvalid(dv[1]), .s_data_tready(drdy[1]), .s_data_tdata(dd[1]),
    .s_data_tkeep(dk[1]), .s_data_tid(dt[1]), .s_data_tlast(dl[1]),
    .s_dig_tvalid(gv[1]), .s_dig_tready(grdy[1]), .s_dig_tdata(gd[1][255:0]), .s_dig_tid(gt[1]),
    .m_axis_tvalid(mv[1]), .m_axis_tready(mr[1]), .m_axis_tdata(md[1]),
    .m_axis_tkeep(mk[1]), .m_axis_tid(mt[1]), .m_axis_tlast(ml[1]),
    .pkt_cnt(pc[1]), .id_err(ierr[1]), .id_err_cnt(ec[1])
  );

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting", nm);
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int dq_size(input int m); return (m == 0) ? dq0.size() : dq1.size(); endfunction
  function automatic int gq_size(input int m); return (m == 0) ? gq0.size() : gq1.size(); endfunction
  function automatic int eq_size(input int m); return (m == 0) ? eq0.size() : eq1.size(); endfunction
  function automatic pkt_t dq_pop(input int m);
    if (m == 0) return dq0.pop_front();
    return dq1.pop_front();
  endfunction
  function automatic pkt_t gq_pop(input int m);
    if (m == 0) return gq0.pop_front();
    return gq1.pop_front();
  endfunction
  function automatic beat_t eq_pop(input int m);
    if (m == 0) return eq0.pop_front();
    return eq1.pop_front();
  endfunction
  function automatic void eq_push(input int m, input beat_t b);
    if (m == 0) eq0.push_back(b);
    else eq1.push_back(b);
  endfunction

  // Reference model: builds the packet and the beats the merged stream must carry.
  task automatic gen(input int m, input int n, input logic [5:0] tid, input logic [5:0] dtid,
                     input logic [511:0] dig, input int ddly, input bit abort);
    pkt_t p;
    beat_t b;
    logic [511:0] msk = '1;
    logic [63:0] km = '1;
    if (m == 1) begin
      msk[511:256] = '0;
      km[63:32] = '0;
    end
    p = '0;
    p.n = 3'(n); p.tid = tid; p.dtid = dtid; p.dig = dig; p.ddly = 4'(ddly); p.abort = abort;
    for (int i = 0; i < n; i++) begin
      p.dat[i] = rnd512();
      p.keep[i] = {$urandom, $urandom};
    end
    for (int i = 0; i < n; i++) begin
      b.dat = p.dat[i]; b.keep = p.keep[i]; b.tid = tid; b.last = 1'b0;
      if (i == n - 1 && m == 0) begin
        b.dat = dig & msk; b.keep = km; b.last = 1'b1;
      end
      eq_push(m, b);
    end
    if (m == 1 && !abort) begin
      b.dat = dig & msk; b.keep = km; b.tid = tid; b.last = 1'b1;
      eq_push(m, b);
    end
    if (!abort && tid != dtid) exp_err[m]++;
    if (m == 0) begin dq0.push_back(p); gq0.push_back(p); end
    else begin dq1.push_back(p); gq1.push_back(p); end
  endtask

  task automatic data_drv(input int m);
    pkt_t p;
    int cnt;
    dv[m] = 1'b0; dd[m] = '0; dk[m] = '0; dt[m] = '0; dl[m] = 1'b0;
    forever begin
      if (dq_size(m) == 0) begin
        @(posedge clk); #1;
        continue;
      end
      p = dq_pop(m);
      for (int b = 0; b < int'(p.n); b++) begin
        if (rand_mode && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        dv[m] = 1'b1; dd[m] = p.dat[b]; dk[m] = p.keep[b]; dt[m] = p.tid;
        dl[m] = (b == int'(p.n) - 1);
        cnt = 0;
        @(negedge clk);
        while (!drdy[m] && cnt < 3000) begin @(negedge clk); cnt++; end
        if (!drdy[m]) tmo($sformatf("m%0d_data_accept", m));
        @(posedge clk); #1;
        dv[m] = 1'b0;
      end
    end
  endtask

  task automatic dig_drv(input int m);
    pkt_t p;
    int cnt;
    gv[m] = 1'b0; gd[m] = '0; gt[m] = '0;
    forever begin
      if (gq_size(m) == 0) begin
        @(posedge clk); #1;
        continue;
      end
      p = gq_pop(m);
      if (p.abort) continue;
      cnt = 0;
      @(negedge clk);
      while (!(dv[m] && dl[m]) && cnt < 3000) begin @(negedge clk); cnt++; end
      if (!(dv[m] && dl[m])) tmo($sformatf("m%0d_last_seen", m));
      repeat (int'(p.ddly)) @(posedge clk);
      #1;
      gv[m] = 1'b1; gd[m] = p.dig; gt[m] = p.dtid;
      cnt = 0;
      @(negedge clk);
      while (!grdy[m] && cnt < 3000) begin @(negedge clk); cnt++; end
      if (!grdy[m]) tmo($sformatf("m%0d_dig_accept", m));
      @(posedge clk); #1;
      gv[m] = 1'b0;
    end
  endtask

  task automatic mon(input int m);
    int lastcnt = 0;
    bit hold = 1'b0;
    beat_t e, held;
    forever begin
      @(negedge clk);
      if (rst[m]) begin
        lastcnt = 0; errseen[m] = 0; hold = 1'b0;
        continue;
      end
      if (ierr[m]) errseen[m]++;
      if (hold) begin
        chk($sformatf("m%0d_stall_tdata", m), md[m], held.dat);
        chk($sformatf("m%0d_stall_ctl", m), {mv[m], mk[m], mt[m], ml[m]},
            {1'b1, held.keep, held.tid, held.last});
      end
      hold = 1'b0;
      if (mv[m] && !mr[m]) begin
        hold = 1'b1;
        held.dat = md[m]; held.keep = mk[m]; held.tid = mt[m]; held.last = ml[m];
      end
      if (mv[m] && mr[m]) begin
        if (eq_size(m) == 0) begin
          checks++; failures++;
          $display("FAIL m%0d_extra_beat: got beat tid=%0h last=%0b, expected none", m, mt[m], ml[m]);
        end else begin
          e = eq_pop(m);
          chk($sformatf("m%0d_tdata", m), md[m], e.dat);
          chk($sformatf("m%0d_tkeep", m), mk[m], e.keep);
          chk($sformatf("m%0d_tid", m), mt[m], e.tid);
          chk($sformatf("m%0d_tlast", m), ml[m], e.last);
        end
        chk($sformatf("m%0d_pkt_cnt_run", m), pc[m], lastcnt);
        if (ml[m]) lastcnt++;
      end
    end
  endtask

  task automatic drain(input int m, input int limit);
    int cnt = 0;
    @(negedge clk);
    while ((eq_size(m) != 0 || mv[m]) && cnt < limit) begin @(negedge clk); cnt++; end
    if (eq_size(m) != 0 || mv[m]) tmo($sformatf("m%0d_drain", m));
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset(input int m, input string tag);
    chk($sformatf("%s_m%0d_tvalid", tag, m), mv[m], 1'b0);
    chk($sformatf("%s_m%0d_tdata", tag, m), md[m], '0);
    chk($sformatf("%s_m%0d_tkeep_tid_tlast", tag, m), {mk[m], mt[m], ml[m]}, '0);
    chk($sformatf("%s_m%0d_pkt_cnt", tag, m), pc[m], 32'd0);
    chk($sformatf("%s_m%0d_id_err", tag, m), {ierr[m], ec[m]}, '0);
    chk($sformatf("%s_m%0d_treadys", tag, m), {drdy[m], grdy[m]}, 2'b00);
  endtask

  initial data_drv(0);
  initial data_drv(1);
  initial dig_drv(0);
  initial dig_drv(1);
  initial mon(0);
  initial mon(1);

  initial begin
    mr[0] = 1'b1; mr[1] = 1'b1;
    forever begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) mr[m] = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int n;
    logic [5:0] tid, dtid;
    exp_err[0] = 0; exp_err[1] = 0;
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset(0, "por");
    chk_reset(1, "por");
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;

    // Replace mode: 3-beat packet with matching digest
    gen(0, 3, 6'd5, 6'd5, {32{16'hABCD}}, 1, 1'b0);
    drain(0, 200);
    chk("rep3_pkt_cnt", pc[0], 32'd1);
    chk("rep3_id_err_cnt", ec[0], 16'd0);

    // Replace mode: digest arrives 10 cycles after the last data beat
    gen(0, 2, 6'd9, 6'd9, rnd512(), 10, 1'b0);
    cnt = 0;
    @(negedge clk);
    while (!(dv[0] && dl[0]) && cnt < 100) begin @(negedge clk); cnt++; end
    if (!(dv[0] && dl[0])) tmo("late_dig_last_beat");
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("late_dig_no_hs_%0d", c), {drdy[0], grdy[0]}, 2'b00);
    end
    @(negedge clk);
    chk("late_dig_joint_ready", {drdy[0], grdy[0]}, 2'b11);
    @(negedge clk);
    chk("late_dig_out_next_cycle", {mv[0], ml[0]}, 2'b11);
    drain(0, 200);

    // Replace mode: tid mismatch still merges, one error pulse
    gen(0, 1, 6'd3, 6'd7, rnd512(), 1, 1'b0);
    drain(0, 200);
    chk("mismatch_pulses", errseen[0], 1);
    chk("mismatch_id_err_cnt", ec[0], 16'd1);
    chk("mismatch_pkt_cnt", pc[0], 32'd3);

    // Append mode: 2-beat packet
    gen(1, 2, 6'd2, 6'd2, rnd512(), 1, 1'b0);
    drain(1, 200);
    chk("app2_pkt_cnt", pc[1], 32'd1);
    chk("app2_id_err_cnt", ec[1], 16'd0);

    // Clear both instances, then random traffic under backpressure
    @(posedge clk); #1;
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    exp_err[0] = 0; exp_err[1] = 0;
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      for (int m = 0; m < 2; m++) begin
        n = $urandom_range(1, 4);
        tid = 6'($urandom);
        dtid = ($urandom_range(0, 7) == 0) ? (tid ^ 6'($urandom_range(1, 63))) : tid;
        gen(m, n, tid, dtid, rnd512(), $urandom_range(1, 3), 1'b0);
      end
    end
    drain(0, 40000);
    drain(1, 40000);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rand_m%0d_pkt_cnt", m), pc[m], 32'd1000);
      chk($sformatf("rand_m%0d_id_err_cnt", m), ec[m], 16'(exp_err[m]));
      chk($sformatf("rand_m%0d_id_err_pulses", m), errseen[m], exp_err[m]);
    end
    rand_mode = 1'b0;
    repeat (3) @(posedge clk);

    // Append mode: reset while waiting for a digest
    gen(1, 2, 6'd4, 6'd4, rnd512(), 1, 1'b1);
    drain(1, 200);
    chk("abort_waiting_digest", {drdy[1], grdy[1]}, 2'b01);
    @(posedge clk); #1;
    rst[1] = 1'b1;
    gen(1, 1, 6'd6, 6'd6, rnd512(), 1, 1'b0);
    repeat (2) @(negedge clk);
    chk_reset(1, "midpkt");
    @(posedge clk); #1;
    rst[1] = 1'b0;
    drain(1, 200);
    chk("post_reset_pkt_cnt", pc[1], 32'd1);
    chk("post_reset_id_err_cnt", ec[1], 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
